iq_acc_start_ctrl: RTL and testbench

Control stage directly downstream of the `acc_iq_start_acc` software register. It turns the register's `user_data_out` word into a frame-aligned accumulation window for the IQ accumulator. On a rising edge of the start bit it arms, waits for the next frame boundary, and then qualifies exactly `acc_len` whole frames of IQ samples with first/last flags. When the window closes it pulses done and returns to idle.

---
 rtl/iq_acc_pkg.sv | 16 +
 rtl/iq_acc_start_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_iq_acc_start_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iq_acc_pkg.sv
// Shared definitions for the IQ accumulator start control: FSM states and
// the field layout of the acc_iq_start_acc software register word.
package iq_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int START_BIT = 0;
  localparam int ABORT_BIT = 1;
  localparam int LEN_LSB   = 16;

endpackage

// File: rtl/iq_acc_start_ctrl.sv
// Turns the start register into a frame-aligned accumulation window: arm on
// a start edge, wait for a frame boundary, qualify acc_len whole frames with
// first/last flags, then pulse done. Every output is a flop.
module iq_acc_start_ctrl
  import iq_acc_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int IQ_W  = 32
) (
  input  logic            user_clk,
  input  logic            user_rst,
  input  logic [31:0]     start_reg,
  input  logic            in_valid,
  input  logic            in_sync,
  input  logic [IQ_W-1:0] in_data,
  output logic            acc_en,
  output logic            acc_first,
  output logic            acc_last,
  output logic [IQ_W-1:0] acc_data,
  output logic            acc_done,
  output logic            busy,
  output logic            overrun
);

  state_e state_q, state_d;

  logic             start_q, start_d;
  logic             arm_ok_q, arm_ok_d;
  logic [LEN_W-1:0] len_lat_q, len_lat_d;
  logic [LEN_W-1:0] frame_idx_q, frame_idx_d;
  logic             overrun_q, overrun_d;

  logic             acc_en_q, acc_en_d;
  logic             acc_first_q, acc_first_d;
  logic             acc_last_q, acc_last_d;
  logic [IQ_W-1:0]  acc_data_q, acc_data_d;
  logic             acc_done_q, acc_done_d;
  logic             busy_q, busy_d;

  logic             start_bit;
  logic             abort;
  logic [LEN_W-1:0] acc_len;
  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] len_last;
  logic             start_edge;
  logic             busy_now;
  logic             accept_start;
  logic             sync_hit;
  logic             sample_take;
  logic [LEN_W-1:0] sample_idx;
  logic [31:0]      unused_start_reg;

  assign start_bit        = start_reg[START_BIT];
  assign abort            = start_reg[ABORT_BIT];
  assign acc_len          = start_reg[LEN_LSB +: LEN_W];
  assign unused_start_reg = start_reg;

  // arm_ok_q is low for the first clock after reset, so a start bit held
  // high across reset is absorbed into start_q instead of looking like an edge.
  assign start_edge   = start_bit & ~start_q & arm_ok_q;
  assign len_eff      = (acc_len == '0) ? LEN_W'(1) : acc_len;
  assign len_last     = len_lat_q - LEN_W'(1);
  assign busy_now     = (state_q == ARMED) || (state_q == ACCUM);
  assign accept_start = start_edge & ~abort & ((state_q == IDLE) || (state_q == DONE));
  assign sync_hit     = in_valid & in_sync;

  // Which frame the current sample falls in, and whether it is accumulated;
  // the sync that starts the frame after the last one closes the window instead.
  always_comb begin
    sample_idx  = frame_idx_q;
    sample_take = 1'b0;
    if (state_q == ARMED) begin
      sample_idx  = '0;
      sample_take = sync_hit & ~abort;
    end else if (state_q == ACCUM) begin
      sample_idx  = in_sync ? (frame_idx_q + LEN_W'(1)) : frame_idx_q;
      sample_take = in_valid & ~abort & ~(in_sync & (frame_idx_q == len_last));
    end
  end

  // State register.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort wins over every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = accept_start ? ARMED : IDLE;
      ARMED: begin
        if (abort) begin
          state_d = IDLE;
        end else if (sync_hit) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (abort) begin
          state_d = IDLE;
        end else if (sync_hit && (frame_idx_q == len_last)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bookkeeping: edge history, latched length, frame counter, sticky overrun.
  always_comb begin
    start_d     = start_bit;
    arm_ok_d    = 1'b1;
    len_lat_d   = len_lat_q;
    frame_idx_d = frame_idx_q;
    overrun_d   = overrun_q;
    if (accept_start) begin
      len_lat_d   = len_eff;
      frame_idx_d = '0;
      overrun_d   = 1'b0;
    end else begin
      if (sample_take) begin
        frame_idx_d = sample_idx;
      end
      if (start_edge && busy_now) begin
        overrun_d = 1'b1;
      end
    end
  end

  // Output decode, registered one cycle behind the sample it describes.
  always_comb begin
    acc_en_d    = sample_take;
    acc_first_d = sample_take & (sample_idx == '0);
    acc_last_d  = sample_take & (sample_idx == len_last);
    acc_data_d  = in_data;
    acc_done_d  = (state_d == DONE);
    busy_d      = (state_d == ARMED) || (state_d == ACCUM);
  end

  // Registers for bookkeeping and outputs; reset clears everything at once.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      start_q     <= 1'b0;
      arm_ok_q    <= 1'b0;
      len_lat_q   <= '0;
      frame_idx_q <= '0;
      overrun_q   <= 1'b0;
      acc_en_q    <= 1'b0;
      acc_first_q <= 1'b0;
      acc_last_q  <= 1'b0;
      acc_data_q  <= '0;
      acc_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      start_q     <= start_d;
      arm_ok_q    <= arm_ok_d;
      len_lat_q   <= len_lat_d;
      frame_idx_q <= frame_idx_d;
      overrun_q   <= overrun_d;
      acc_en_q    <= acc_en_d;
      acc_first_q <= acc_first_d;
      acc_last_q  <= acc_last_d;
      acc_data_q  <= acc_data_d;
      acc_done_q  <= acc_done_d;
      busy_q      <= busy_d;
    end
  end

  assign acc_en    = acc_en_q;
  assign acc_first = acc_first_q;
  assign acc_last  = acc_last_q;
  assign acc_data  = acc_data_q;
  assign acc_done  = acc_done_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_iq_acc_start_ctrl.sv
// Bench for iq_acc_start_ctrl. The reference model counts frame syncs since
// arming and derives each sample's frame number arithmetically.
module tb_iq_acc_start_ctrl;

  localparam int LEN_W = 16;
  localparam int IQ_W  = 32;

  logic            user_clk = 1'b0;
  logic            user_rst;
  logic [31:0]     start_reg;
  logic            in_valid;
  logic            in_sync;
  logic [IQ_W-1:0] in_data;
  logic            acc_en;
  logic            acc_first;
  logic            acc_last;
  logic [IQ_W-1:0] acc_data;
  logic            acc_done;
  logic            busy;
  logic            overrun;

  iq_acc_start_ctrl #(.LEN_W(LEN_W), .IQ_W(IQ_W)) dut (
    .user_clk  (user_clk),
    .user_rst  (user_rst),
    .start_reg (start_reg),
    .in_valid  (in_valid),
    .in_sync   (in_sync),
    .in_data   (in_data),
    .acc_en    (acc_en),
    .acc_first (acc_first),
    .acc_last  (acc_last),
    .acc_data  (acc_data),
    .acc_done  (acc_done),
    .busy      (busy),
    .overrun   (overrun)
  );

  // Free-running clock.
  always #5 user_clk = ~user_clk;

  int compared   = 0;
  int mismatched = 0;

  logic st_bit;
  logic ab_bit;
  int   len_field;

  bit          m_active;
  int          m_syncs;
  int          m_len;
  logic        m_prev_start;
  logic        e_en, e_first, e_last, e_done, e_busy, e_ovr;
  logic [31:0] e_data;

  int en_cnt, first_cnt, last_cnt, done_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active     = 1'b0;
    m_syncs      = 0;
    m_len        = 1;
    m_prev_start = 1'b1;
    e_en = 1'b0; e_first = 1'b0; e_last = 1'b0;
    e_done = 1'b0; e_busy = 1'b0; e_ovr = 1'b0;
    e_data = '0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic [31:0] d);
    logic rose;
    rose         = st_bit & ~m_prev_start;
    m_prev_start = st_bit;
    e_en = 1'b0; e_first = 1'b0; e_last = 1'b0; e_done = 1'b0;
    e_data = d;
    if (m_active) begin
      if (rose) e_ovr = 1'b1;
      if (ab_bit) begin
        m_active = 1'b0;
      end else if (v) begin
        if (s) m_syncs++;
        if (m_syncs >= 1 && m_syncs <= m_len) begin
          e_en    = 1'b1;
          e_first = (m_syncs == 1);
          e_last  = (m_syncs == m_len);
        end
        if (m_syncs == m_len + 1) begin
          e_done   = 1'b1;
          m_active = 1'b0;
        end
      end
    end else if (rose && !ab_bit) begin
      m_active = 1'b1;
      m_syncs  = 0;
      m_len    = (len_field == 0) ? 1 : len_field;
      e_ovr    = 1'b0;
    end
    e_busy = m_active;
  endtask

  task automatic checkOutput();
    chk("acc_en",    {31'd0, acc_en},    {31'd0, e_en});
    chk("acc_first", {31'd0, acc_first}, {31'd0, e_first});
    chk("acc_last",  {31'd0, acc_last},  {31'd0, e_last});
    chk("acc_data",  acc_data,           e_data);
    chk("acc_done",  {31'd0, acc_done},  {31'd0, e_done});
    chk("busy",      {31'd0, busy},      {31'd0, e_busy});
    chk("overrun",   {31'd0, overrun},   {31'd0, e_ovr});
    if (acc_en)    en_cnt++;
    if (acc_first) first_cnt++;
    if (acc_last)  last_cnt++;
    if (acc_done)  done_cnt++;
  endtask

  task automatic clear_counts();
    en_cnt = 0; first_cnt = 0; last_cnt = 0; done_cnt = 0;
  endtask

  task automatic applyStimulus(input logic v, input logic s, input logic [31:0] d);
    logic [31:0] lf;
    lf        = len_field;
    start_reg = {lf[15:0], 14'($urandom), ab_bit, st_bit};
    in_valid  = v;
    in_sync   = s;
    in_data   = d;
    model_step(v, s, d);
    @(posedge user_clk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), $urandom);
  endtask

  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) begin
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, 1'($urandom_range(0, 1)), $urandom);
        applyStimulus(1'b1, (k == 0), $urandom);
      end
    end
  endtask

  initial begin
    logic v;
    logic s;
    st_bit = 1'b0; ab_bit = 1'b0; len_field = 0;
    start_reg = '0; in_valid = 1'b0; in_sync = 1'b0; in_data = '0;
    user_rst = 1'b1;
    model_reset();
    clear_counts();
    repeat (2) @(posedge user_clk);
    #1;
    checkOutput();
    user_rst = 1'b0;
    idle(2);

    $display("[TB] acc_len=3 over four frames");
    clear_counts();
    len_field = 3;
    idle(3);
    st_bit = 1'b1;
    applyStimulus(1'b1, 1'b0, $urandom);
    run_frames(4);
    idle(3);
    chk("t1_en_cnt", en_cnt, 24);
    chk("t1_first_cnt", first_cnt, 8);
    chk("t1_last_cnt", last_cnt, 8);
    chk("t1_done_cnt", done_cnt, 1);
    st_bit = 1'b0;
    idle(2);

    $display("[TB] acc_len=0 behaves as one frame");
    clear_counts();
    len_field = 0;
    st_bit = 1'b1;
    idle(1);
    run_frames(2);
    idle(2);
    chk("t2_en_cnt", en_cnt, 8);
    chk("t2_first_cnt", first_cnt, 8);
    chk("t2_last_cnt", last_cnt, 8);
    chk("t2_done_cnt", done_cnt, 1);
    st_bit = 1'b0;
    idle(1);

    $display("[TB] start edge coincident with sync");
    clear_counts();
    len_field = 2;
    st_bit = 1'b1;
    applyStimulus(1'b1, 1'b1, $urandom);
    repeat (5) applyStimulus(1'b1, 1'b0, $urandom);
    chk("t3_no_early_en", en_cnt, 0);
    run_frames(3);
    idle(2);
    chk("t3_en_cnt", en_cnt, 16);
    chk("t3_done_cnt", done_cnt, 1);
    st_bit = 1'b0;
    idle(1);

    $display("[TB] second start edge mid-window");
    clear_counts();
    len_field = 3;
    st_bit = 1'b1;
    idle(1);
    run_frames(1);
    st_bit = 1'b0;
    applyStimulus(1'b0, 1'b0, $urandom);
    st_bit = 1'b1;
    applyStimulus(1'b0, 1'b0, $urandom);
    chk("t4_overrun_set", {31'd0, overrun}, 32'd1);
    run_frames(3);
    idle(2);
    chk("t4_en_cnt", en_cnt, 24);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_overrun_sticky", {31'd0, overrun}, 32'd1);
    st_bit = 1'b0;
    idle(1);
    st_bit = 1'b1;
    idle(1);
    chk("t4_overrun_clr", {31'd0, overrun}, 32'd0);
    chk("t4_rearmed", {31'd0, busy}, 32'd1);
    ab_bit = 1'b1;
    idle(1);
    ab_bit = 1'b0;
    st_bit = 1'b0;
    idle(1);

    $display("[TB] abort during frame 1 of 3");
    clear_counts();
    len_field = 3;
    st_bit = 1'b1;
    idle(1);
    run_frames(1);
    applyStimulus(1'b1, 1'b1, $urandom);
    repeat (3) applyStimulus(1'b1, 1'b0, $urandom);
    ab_bit = 1'b1;
    applyStimulus(1'b1, 1'b0, $urandom);
    chk("t5_abort_en", {31'd0, acc_en}, 32'd0);
    chk("t5_abort_busy", {31'd0, busy}, 32'd0);
    ab_bit = 1'b0;
    run_frames(2);
    chk("t5_no_done", done_cnt, 0);
    chk("t5_en_cnt", en_cnt, 12);
    st_bit = 1'b0;
    idle(1);

    $display("[TB] reset mid-window with start held high");
    len_field = 3;
    st_bit = 1'b1;
    idle(1);
    run_frames(1);
    applyStimulus(1'b1, 1'b1, $urandom);
    applyStimulus(1'b1, 1'b0, $urandom);
    chk("t6_busy_before", {31'd0, busy}, 32'd1);
    #2;
    user_rst = 1'b1;
    #1;
    chk("t6_rst_en", {31'd0, acc_en}, 32'd0);
    chk("t6_rst_first", {31'd0, acc_first}, 32'd0);
    chk("t6_rst_data", acc_data, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    model_reset();
    @(posedge user_clk);
    #1;
    checkOutput();
    user_rst = 1'b0;
    clear_counts();
    run_frames(2);
    chk("t6_held_no_en", en_cnt, 0);
    st_bit = 1'b0;
    idle(1);
    st_bit = 1'b1;
    idle(1);
    chk("t6_rearm_busy", {31'd0, busy}, 32'd1);
    run_frames(4);
    idle(2);
    chk("t6_en_cnt", en_cnt, 24);
    chk("t6_done_cnt", done_cnt, 1);

    $display("[TB] randomized soak");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) st_bit = ~st_bit;
      ab_bit = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) len_field = $urandom_range(0, 3);
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 5) == 0);
      applyStimulus(v, s, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
